// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: forwards the HPS ROM download to the core and holds the core in reset until a full image is resident.
module rom_load_sequencer #(
  parameter int TOTAL_BYTES = 81920,
  parameter int CPU_END     = 65536,
  parameter int GFX_END     = 73728,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rst_req,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [1:0]  dn_region,
  output logic        game_reset,
  output logic        rom_ok,
  output logic        led_busy,
  output logic [17:0] byte_count
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [24:0] TOT_A = 25'(TOTAL_BYTES);
  localparam logic [24:0] CPU_A = 25'(CPU_END);
  localparam logic [24:0] GFX_A = 25'(GFX_END);
  localparam logic [17:0] TOT_C = 18'(TOTAL_BYTES);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;
  state_t        r_state;
  logic [CW-1:0] r_hold;
  logic          r_overflow;
  logic          w_wr;
  logic          w_in;
  logic          w_ovf;
  logic [17:0]   w_cnt;
  logic [1:0]    w_region;
  // The load-exit decision must see a write arriving in the same cycle as the download drop.
  always_comb begin
    w_wr     = r_state == LOAD && ioctl_wr;
    w_in     = ioctl_addr < TOT_A;
    w_ovf    = r_overflow | (w_wr & ~w_in);
    w_cnt    = (w_wr && w_in && byte_count != '1) ? byte_count + 18'd1 : byte_count;
    w_region = ioctl_addr < CPU_A ? 2'd0 : ioctl_addr < GFX_A ? 2'd1 : 2'd2;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_overflow <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_wr      <= 1'b0;
      dn_region  <= '0;
      game_reset <= 1'b1;
      rom_ok     <= 1'b0;
      led_busy   <= 1'b0;
      byte_count <= '0;
    end else begin
      dn_wr <= 1'b0;
      if (r_state == LOAD) begin
        if (w_wr && w_in) begin
          dn_wr     <= 1'b1;
          dn_addr   <= ioctl_addr[16:0];
          dn_data   <= ioctl_dout;
          dn_region <= w_region;
        end
        byte_count <= w_cnt;
        r_overflow <= w_ovf;
        if (!ioctl_download) begin
          led_busy <= 1'b0;
          if (w_cnt == TOT_C && !w_ovf) begin
            r_state <= HOLD;
            rom_ok  <= 1'b1;
            r_hold  <= HOLD_LAST;
          end else begin
            r_state <= ERR;
          end
        end
      end else if (ioctl_download) begin
        r_state    <= LOAD;
        byte_count <= '0;
        r_overflow <= 1'b0;
        rom_ok     <= 1'b0;
        led_busy   <= 1'b1;
        game_reset <= 1'b1;
      end else if (rst_req && (r_state == HOLD || r_state == RUN)) begin
        r_state    <= HOLD;
        r_hold     <= HOLD_LAST;
        game_reset <= 1'b1;
      end else if (r_state == HOLD) begin
        if (r_hold == '0) begin
          r_state    <= RUN;
          game_reset <= 1'b0;
        end else begin
          r_hold <= r_hold - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed scenarios plus randomized download sessions against an event-time model of the loader.
module tb_rom_load_sequencer;
  localparam int TB = 8, CE = 4, GE = 6, HC = 4;
  logic        clk = 0, reset = 1, dl = 0, wr = 0, rr = 0;
  logic [24:0] addr = 0;
  logic [7:0]  dout = 0;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;
  logic        game_reset, rom_ok, led_busy;
  logic [17:0] byte_count;
  int checks = 0, errors = 0;
  bit m_on = 0, m_load = 0, m_good = 0, m_ovf = 0, m_wr = 0;
  int m_n = 0, m_rel = 0, m_cnt = 0, m_addr = 0, m_data = 0, m_reg = 0;
  int k;
  int reg_exp [8] = '{0, 0, 0, 0, 1, 1, 2, 2};

  always #5 clk = ~clk;

  rom_load_sequencer #(.TOTAL_BYTES(TB), .CPU_END(CE), .GFX_END(GE), .HOLD_CYCLES(HC)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr), .ioctl_addr(addr),
    .ioctl_dout(dout), .rst_req(rr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .dn_region(dn_region), .game_reset(game_reset), .rom_ok(rom_ok), .led_busy(led_busy),
    .byte_count(byte_count));

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the core runs once an accepted image exists, no load is active, and HC edges have
  // passed since the image completed or since the last user reset request.
  task automatic step();
    m_n++;
    if (reset) begin
      m_load = 0; m_good = 0; m_ovf = 0; m_cnt = 0; m_wr = 0; m_addr = 0; m_data = 0; m_reg = 0;
    end else begin
      m_wr = 0;
      if (m_load) begin
        if (wr) begin
          if (addr < TB) begin
            m_wr = 1; m_addr = int'(addr[16:0]); m_data = int'(dout);
            m_reg = addr < CE ? 0 : addr < GE ? 1 : 2;
            if (m_cnt < 262143) m_cnt++;
          end else m_ovf = 1;
        end
        if (!dl) begin
          m_load = 0;
          if (m_cnt == TB && !m_ovf) begin m_good = 1; m_rel = m_n + HC; end
        end
      end else if (dl) begin
        m_load = 1; m_cnt = 0; m_ovf = 0; m_good = 0;
      end else if (rr && m_good) m_rel = m_n + HC;
    end
    m_on = 1;
  endtask

  initial forever begin
    @(posedge clk);
    step();
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      check("dn_wr", int'(dn_wr), int'(m_wr));
      check("dn_addr", int'(dn_addr), m_addr);
      check("dn_data", int'(dn_data), m_data);
      check("dn_region", int'(dn_region), m_reg);
      check("game_reset", int'(game_reset), int'(!(m_good && !m_load && m_n >= m_rel)));
      check("rom_ok", int'(rom_ok), int'(m_good));
      check("led_busy", int'(led_busy), int'(m_load));
      check("byte_count", int'(byte_count), m_cnt);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input int nb, input bit coinc);
    dl = 1; cyc();
    for (int i = 0; i < nb; i++) begin
      wr = 1; addr = 25'(i); dout = 8'(8'hA0 + i);
      if (coinc && i == nb - 1) dl = 0;
      cyc();
      check("lit_dn_wr", int'(dn_wr), 1);
      check("lit_dn_data", int'(dn_data), 8'hA0 + i);
      check("lit_region", int'(dn_region), reg_exp[i]);
      wr = 0;
    end
    if (!coinc) begin dl = 0; cyc(); end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (game_reset && n < 20) begin cyc(); n++; end
  endtask

  task automatic rand_load();
    int n = $urandom_range(7, 9);
    int r;
    dl = 1; rr = 1'($urandom_range(0, 1)); cyc(); rr = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      r = $urandom_range(0, 19);
      wr = 1; dout = 8'($urandom);
      addr = r < 17 ? 25'(i) : r < 19 ? 25'($urandom_range(0, 7)) : 25'($urandom_range(8, 33554431));
      if (i == n - 1 && $urandom_range(0, 3) == 0) dl = 0;
      if ($urandom_range(0, 59) == 0) reset = 1;
      cyc(); wr = 0; reset = 0;
    end
    dl = 0; cyc();
  endtask

  initial begin
    cyc(); cyc();
    check("rst_game_reset", int'(game_reset), 1);
    check("rst_rom_ok", int'(rom_ok), 0);
    check("rst_dn_wr", int'(dn_wr), 0);
    check("rst_byte_count", int'(byte_count), 0);
    check("rst_led_busy", int'(led_busy), 0);
    reset = 0; cyc();
    load(8, 0);
    check("full_rom_ok", int'(rom_ok), 1);
    check("full_count", int'(byte_count), 8);
    check("full_hold_reset", int'(game_reset), 1);
    wait_release(k);
    check("full_release_cycles", k, 4);
    load(7, 0);
    check("short_rom_ok", int'(rom_ok), 0);
    check("short_count", int'(byte_count), 7);
    rr = 1; cyc(); rr = 0;
    repeat (6) cyc();
    check("err_ignores_rst_req", int'(game_reset), 1);
    load(8, 0);
    wait_release(k);
    check("after_err_release", k, 4);
    dl = 1; cyc();
    for (int i = 0; i < 9; i++) begin
      wr = 1; addr = 25'(i); dout = 8'(i); cyc();
      if (i == 8) check("oob_no_dn_wr", int'(dn_wr), 0);
    end
    wr = 0; dl = 0; cyc();
    check("oob_rom_ok", int'(rom_ok), 0);
    check("oob_count", int'(byte_count), 8);
    load(8, 0);
    wait_release(k);
    rr = 1; cyc(); rr = 0;
    wait_release(k);
    check("rst_pulse_release", k, 4);
    rr = 1; repeat (3) cyc();
    check("rst_held_reset", int'(game_reset), 1);
    rr = 0;
    wait_release(k);
    check("rst_held_release", k, 4);
    load(8, 1);
    check("coinc_rom_ok", int'(rom_ok), 1);
    check("coinc_count", int'(byte_count), 8);
    wait_release(k);
    check("coinc_release", k, 4);
    rr = 1; dl = 1; cyc(); rr = 0;
    check("dl_beats_rst", int'(led_busy), 1);
    for (int i = 0; i < 3; i++) begin wr = 1; addr = 25'(i); cyc(); end
    reset = 1; wr = 1; addr = 3; cyc();
    reset = 0; dl = 0;
    check("midload_count", int'(byte_count), 0);
    check("midload_rom_ok", int'(rom_ok), 0);
    check("midload_dn_wr", int'(dn_wr), 0);
    addr = 0; cyc(); wr = 0;
    check("idle_wr_dn_wr", int'(dn_wr), 0);
    check("idle_wr_count", int'(byte_count), 0);
    load(8, 0);
    wait_release(k);
    wr = 1; addr = 2; cyc(); wr = 0;
    check("run_wr_dn_wr", int'(dn_wr), 0);
    check("run_wr_count", int'(byte_count), 8);
    for (int s = 0; s < 150; s++) begin
      rand_load();
      repeat ($urandom_range(3, 12)) begin
        wr = 1'($urandom_range(0, 3) == 0); addr = 25'($urandom_range(0, 9));
        rr = 1'($urandom_range(0, 5) == 0);
        cyc();
      end
      wr = 0; rr = 0;
    end
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
